conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming 3x3 window generator that feeds the convolution datapath. Accepts one 8-bit pixel per cycle in raster order over a valid/ready handshake. Buffers the two previous image rows internally. Emits every fully-populated 3x3 neighbourhood (no padding) as a 72-bit packed window, in the same packing the convolution unit consumes on its `image` bus, with a last-window marker per frame.

## Interface

Parameters:
- IMG_WIDTH, 8, pixels per row; must be ≥3
- IMG_HEIGHT, 8, rows per frame; must be ≥3

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset, one clock domain
- pix_in  input  8  unsigned pixel, raster order (row-major, left to right)
- pix_valid  input  1  pix_in is valid this cycle
- pix_ready  output  1  block accepts pix_in this cycle; transfer = pix_valid & pix_ready
- win_out  output  72  packed window; byte i = win_out[i*8 +: 8], i = 3*wr + wc; wr 0 = top (oldest row), wc 0 = leftmost
- win_valid  output  1  win_out/win_last hold a window
- win_ready  input  1  downstream accepts window; transfer = win_valid & win_ready
- win_last  output  1  qualifies the final window of a frame

## Operation

- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1), $clog2-sized, advance only on an input transfer. col wraps to 0 and increments row; after (IMG_HEIGHT-1, IMG_WIDTH-1), both return to 0.
- Line buffers: lb0 holds row r-1 and lb1 holds row r-2, each IMG_WIDTH×8. On accepting pixel p at column c: new column = {lb1[c], lb0[c], p} (top→bottom); lb1[c]←lb0[c]; lb0[c]←p.
- Window register: 3 columns × 3 rows. Each accept shifts the register left (wc0←wc1, wc1←wc2, wc2←new column). The register does not reset at row start; stale columns are never emitted.
- Emit rule: the accepted pixel is at row ≥2 and col ≥2. The shifted window is then loaded into win_out, win_valid is set, and win_last = (row==IMG_HEIGHT-1 && col==IMG_WIDTH-1).
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Consecutive frames follow without gaps; each frame's first two rows refill the line buffers.
- FSM states:
  - FILL: row <2; accept pixels, no emits.
  - STREAM: row ≥2; accept and emit per rule.
  - DRAIN: entered after accepting the frame's last pixel; pix_ready=0 until the win_last window transfers, then FILL with counters at 0.
  - Transitions: FILL→STREAM on accepting (1, IMG_WIDTH-1). STREAM→DRAIN on accepting the last pixel.
- Arithmetic: none on pixel data; pixels pass through bit-exact, unsigned.

## Timing

- Reset (rst_n=0, async) forces: state=FILL, col=row=0, win_valid=0, win_last=0, win_out=0, pix_ready=0 while asserted. Line buffer and window register contents are not reset.
- First cycle after reset release: pix_ready=1.
- pix_ready = (state≠DRAIN) & (!win_valid | win_ready). This is a single output register with pass-through ready, so there are no bubbles at full rate.
- Latency: the window is visible on win_out with win_valid=1 in the cycle after the accept of its bottom-right pixel.
- Throughput: one pixel and at most one window per cycle when win_ready stays 1.
- Backpressure: while win_valid=1 and win_ready=0, win_out, win_last and win_valid hold stable and pix_ready=0.
- Simultaneous window transfer and new emit in the same cycle: the register reloads and win_valid stays 1. Transfer with no emit clears win_valid.
- pix_valid while pix_ready=0 is ignored; the source holds its data.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0) and no window from the old frame appears.

## Test plan

- IMG_WIDTH=IMG_HEIGHT=4, pixels 0..15 at full rate, win_ready=1:
  - Exactly 4 windows.
  - First window bytes 0..8 = 0,1,2,4,5,6,8,9,10, one cycle after pixel 10 is accepted.
  - Last window = 5,6,7,9,10,11,13,14,15 with win_last=1, and win_last=0 on the others.
- Same frame with win_ready=0 for 5 cycles after the first window:
  - win_out stays 0,1,2,4,5,6,8,9,10.
  - pix_ready=0 throughout.
  - No pixel is lost; the remaining 3 windows are correct.
- Random pix_valid gaps (~50%) with defaults 8x8 → 36 windows, all matching a reference 3x3 extraction model, and win_last only on the 36th.
- Two back-to-back 4x4 frames (values 0..15, then 100..115):
  - pix_ready=0 during DRAIN only.
  - The second frame's first window = 100,101,102,104,105,106,108,109,110, with no mixing of frame-1 data.
- rst_n pulsed low after 9 accepted pixels of a 4x4 frame:
  - win_valid=0 and pix_ready=0 during reset.
  - A fresh 0..15 frame then produces exactly the 4 expected windows.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator over raster-order pixels.
// Two line buffers hold the previous rows; windows leave through one output register.
module conv_window_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] win_out,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        win_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];

    logic [7:0] win_r   [3][3];
    logic [7:0] win_nxt [3][3];
    logic [71:0] win_flat;

    logic accept;
    logic emit;
    logic col_end;
    logic row_end;
    logic out_xfer;

    // Gating with rst_n keeps ready low for the whole time reset is held.
    assign pix_ready = rst_n & (state != DRAIN) & (~win_valid | win_ready);
    assign accept    = pix_valid & pix_ready;
    assign col_end   = (col == CW'(IMG_WIDTH - 1));
    assign row_end   = (row == RW'(IMG_HEIGHT - 1));
    assign emit      = accept & (row >= RW'(2)) & (col >= CW'(2));
    assign out_xfer  = win_valid & win_ready;

    always_comb begin
        win_flat = '0;
        for (int wr = 0; wr < 3; wr++) begin
            win_nxt[wr][0] = win_r[wr][1];
            win_nxt[wr][1] = win_r[wr][2];
        end
        win_nxt[0][2] = lb1[col];
        win_nxt[1][2] = lb0[col];
        win_nxt[2][2] = pix_in;
        for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 3; wc++) begin
                win_flat[(3*wr+wc)*8 +: 8] = win_nxt[wr][wc];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (accept && row == RW'(1) && col_end)
                    state_nxt = STREAM;
            end
            STREAM: begin
                if (accept && row_end && col_end)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_xfer && win_last)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Data storage is deliberately not reset; stale contents never reach win_out.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
            for (int wr = 0; wr < 3; wr++) begin
                for (int wc = 0; wc < 3; wc++) begin
                    win_r[wr][wc] <= win_nxt[wr][wc];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_out   <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (emit) begin
            win_out   <= win_flat;
            win_valid <= 1'b1;
            win_last  <= row_end & col_end;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: vector, directed and randomized checks for conv_window_gen.
// Instance a is 4x4, instance b is 8x8; both are checked against a 3x3 extraction model.
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  a_pix, b_pix;
    logic        a_pv, a_pr, a_wv, a_wr, a_wl;
    logic        b_pv, b_pr, b_wv, b_wr, b_wl;
    logic [71:0] a_win, b_win;

    conv_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .pix_in(a_pix), .pix_valid(a_pv), .pix_ready(a_pr),
        .win_out(a_win), .win_valid(a_wv), .win_ready(a_wr),
        .win_last(a_wl)
    );

    conv_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) u_b (
        .clk(clk), .rst_n(rst_n),
        .pix_in(b_pix), .pix_valid(b_pv), .pix_ready(b_pr),
        .win_out(b_win), .win_valid(b_wv), .win_ready(b_wr),
        .win_last(b_wl)
    );

    typedef struct {
        logic [71:0] w;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0]  pix;
        logic        exp_v;
        logic        exp_l;
        logic [71:0] exp_w;
    } vec_t;

    exp_t       exp_a[$];
    exp_t       exp_b[$];
    logic [7:0] src[$];
    int checks = 0;
    int errors = 0;
    int a_cnt = 0;
    int b_cnt = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pk9(input int b0, input int b1, input int b2,
                                        input int b3, input int b4, input int b5,
                                        input int b6, input int b7, input int b8);
        logic [71:0] x;
        x = {b8[7:0], b7[7:0], b6[7:0], b5[7:0], b4[7:0],
             b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
        return x;
    endfunction

    // Reference: every full 3x3 neighbourhood of the frame, row-major order.
    task automatic push_frame(input int sel, input int start, input int w, input int h);
        exp_t e;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                e.w = '0;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        e.w[(3*wr+wc)*8 +: 8] = src[start + (r-2+wr)*w + (c-2+wc)];
                e.last = (r == h-1) && (c == w-1);
                if (sel == 0) exp_a.push_back(e);
                else exp_b.push_back(e);
            end
        end
    endtask

    function automatic logic pr_of(input int sel);
        return (sel == 0) ? a_pr : b_pr;
    endfunction

    function automatic int cnt_of(input int sel);
        return (sel == 0) ? a_cnt : b_cnt;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] p);
        if (sel == 0) begin
            a_pv = v;
            a_pix = p;
        end else begin
            b_pv = v;
            b_pix = p;
        end
    endtask

    task automatic send(input int sel, input int start, input int n,
                        input int gap_pct, output int stalls);
        logic v;
        logic acc;
        int budget;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            budget = 0;
            while (!acc) begin
                v = ($urandom_range(0, 99) >= gap_pct);
                drive(sel, v, src[start + i]);
                @(negedge clk);
                acc = v & pr_of(sel);
                if (v && !pr_of(sel)) stalls++;
                @(posedge clk);
                #1;
                budget++;
                if (!acc && budget > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: pixel %0d not accepted in %0d cycles", i, budget);
                    drive(sel, 1'b0, 8'h00);
                    return;
                end
            end
        end
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic wait_win(input int sel, input int target);
        int n;
        n = 0;
        while (cnt_of(sel) < target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki("win_count", cnt_of(sel), target);
    endtask

    exp_t ea, eb;
    logic a_hold = 1'b0, b_hold = 1'b0;
    logic [71:0] a_pw, b_pw;
    logic a_pl, b_pl;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                chk1("a_hold_valid", a_wv, 1'b1);
                chkw("a_hold_win", a_win, a_pw);
                chk1("a_hold_last", a_wl, a_pl);
            end
            if (a_wv && !a_wr) chk1("a_bp_ready", a_pr, 1'b0);
            if (a_wv && a_wr) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_extra: got window %h expected none", a_win);
                end else begin
                    ea = exp_a.pop_front();
                    chkw("a_win", a_win, ea.w);
                    chk1("a_last", a_wl, ea.last);
                end
                a_cnt++;
            end
            a_hold = a_wv && !a_wr;
            a_pw = a_win;
            a_pl = a_wl;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_hold = 1'b0;
        end else begin
            if (b_hold) begin
                chk1("b_hold_valid", b_wv, 1'b1);
                chkw("b_hold_win", b_win, b_pw);
                chk1("b_hold_last", b_wl, b_pl);
            end
            if (b_wv && !b_wr) chk1("b_bp_ready", b_pr, 1'b0);
            if (b_wv && b_wr) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_extra: got window %h expected none", b_win);
                end else begin
                    eb = exp_b.pop_front();
                    chkw("b_win", b_win, eb.w);
                    chk1("b_last", b_wl, eb.last);
                end
                b_cnt++;
            end
            b_hold = b_wv && !b_wr;
            b_pw = b_win;
            b_pl = b_wl;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    vec_t vt[16];
    logic [71:0] w10;
    int st, s1, s2;
    logic b_done;

    initial begin
        w10 = pk9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        for (int k = 0; k < 16; k++) begin
            vt[k].pix = 8'(k);
            vt[k].exp_v = 1'b0;
            vt[k].exp_l = 1'b0;
            vt[k].exp_w = '0;
        end
        vt[10] = '{8'd10, 1'b1, 1'b0, w10};
        vt[11] = '{8'd11, 1'b1, 1'b0, pk9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
        vt[14] = '{8'd14, 1'b1, 1'b0, pk9(4, 5, 6, 8, 9, 10, 12, 13, 14)};
        vt[15] = '{8'd15, 1'b1, 1'b1, pk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};

        rst_n = 1'b0;
        a_pv = 1'b0; a_pix = 8'h00; a_wr = 1'b1;
        b_pv = 1'b0; b_pix = 8'h00; b_wr = 1'b1;
        b_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_a_valid", a_wv, 1'b0);
        chk1("rst_a_last", a_wl, 1'b0);
        chkw("rst_a_win", a_win, 72'h0);
        chk1("rst_a_ready", a_pr, 1'b0);
        chk1("rst_b_valid", b_wv, 1'b0);
        chk1("rst_b_ready", b_pr, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_a_ready", a_pr, 1'b1);
        chk1("post_rst_b_ready", b_pr, 1'b1);
        @(posedge clk);
        #1;

        // Full-rate 4x4 frame against the vector table
        src = {};
        for (int k = 0; k < 16; k++) src.push_back(8'(k));
        push_frame(0, 0, 4, 4);
        a_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            a_pv = 1'b1;
            a_pix = vt[k].pix;
            @(posedge clk);
            #1;
            chk1("vec_valid", a_wv, vt[k].exp_v);
            if (vt[k].exp_v) begin
                chkw("vec_win", a_win, vt[k].exp_w);
                chk1("vec_last", a_wl, vt[k].exp_l);
            end
        end
        a_pv = 1'b0;
        wait_win(0, 4);

        // Backpressure right after the first window
        push_frame(0, 0, 4, 4);
        a_cnt = 0;
        fork
            send(0, 0, 16, 0, st);
            begin
                int n;
                n = 0;
                while (!a_wv && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk1("bp_first_seen", a_wv, 1'b1);
                a_wr = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chkw("bp_win", a_win, w10);
                    chk1("bp_ready", a_pr, 1'b0);
                end
                @(posedge clk);
                #1;
                a_wr = 1'b1;
            end
        join
        wait_win(0, 4);

        // Random 8x8 frame, ~50% valid gaps, random downstream stalls
        src = {};
        for (int k = 0; k < 64; k++) src.push_back(8'($urandom));
        push_frame(1, 0, 8, 8);
        b_cnt = 0;
        fork
            begin
                send(1, 0, 64, 50, st);
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    @(posedge clk);
                    #1;
                    b_wr = ($urandom_range(0, 3) != 0);
                end
                b_wr = 1'b1;
            end
        join
        wait_win(1, 36);
        chki("b_queue_left", exp_b.size(), 0);

        // Two back-to-back 4x4 frames
        src = {};
        for (int k = 0; k < 16; k++) src.push_back(8'(k));
        for (int k = 0; k < 16; k++) src.push_back(8'(100 + k));
        push_frame(0, 0, 4, 4);
        push_frame(0, 16, 4, 4);
        a_cnt = 0;
        send(0, 0, 16, 0, s1);
        send(0, 16, 16, 0, s2);
        chki("f1_stalls", s1, 0);
        chki("f2_stalls", s2, 1);
        wait_win(0, 8);

        // Reset in the middle of a frame
        src = {};
        for (int k = 0; k < 16; k++) src.push_back(8'(k));
        a_cnt = 0;
        send(0, 0, 9, 0, st);
        rst_n = 1'b0;
        #2;
        chk1("mid_rst_valid", a_wv, 1'b0);
        chk1("mid_rst_ready", a_pr, 1'b0);
        chk1("mid_rst_last", a_wl, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk1("mid_rst_ready2", a_pr, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("mid_rel_ready", a_pr, 1'b1);
        @(posedge clk);
        #1;
        push_frame(0, 0, 4, 4);
        send(0, 0, 16, 0, st);
        wait_win(0, 4);
        chki("a_queue_left", exp_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
